// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write FIFO.
// Frame width, parity and stop-bit count are set by parameters.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 20,
   parameter int DATA_BITS    = 8,
   parameter int DEPTH        = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [DATA_BITS-1:0]   wr_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   busy,
   output logic                   TxD
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int NW = $clog2(DATA_BITS + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state, state_nx;
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count_nx;
   logic [BW-1:0]        baud;
   logic [NW-1:0]        bitn;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit, line, push, pop;
   logic                 tick, last_data, last_stop;

   assign push      = wr_en && !full;
   assign tick      = baud == BW'(CLKS_PER_BIT - 1);
   assign last_data = bitn == NW'(DATA_BITS - 1);
   assign last_stop = bitn == NW'(STOP_BITS - 1);

   always_comb begin
      state_nx = state;
      line     = 1'b1;
      pop      = 1'b0;
      unique case (state)
         IDLE: if (!empty) begin
            pop      = 1'b1;
            state_nx = START;
         end
         START: begin
            line = 1'b0;
            if (tick) state_nx = DATA;
         end
         DATA: begin
            line = shreg[0];
            if (tick && last_data)
               state_nx = (PARITY != 0) ? PAR : STOP;
         end
         PAR: begin
            line = par_bit;
            if (tick) state_nx = STOP;
         end
         STOP: if (tick && last_stop) begin
            pop      = !empty;
            state_nx = empty ? IDLE : START;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      count_nx = count;
      unique case ({push, pop})
         2'b10:   count_nx = count + CW'(1);
         2'b01:   count_nx = count - CW'(1);
         default: count_nx = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count    <= count_nx;
         full     <= count_nx == CW'(DEPTH);
         empty    <= count_nx == '0;
         overflow <= wr_en && full;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Line and busy are registered from the current state, so both
   // lag the FSM by one clock and stay aligned with each other.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         baud    <= '0;
         bitn    <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         TxD     <= 1'b1;
         busy    <= 1'b0;
      end else begin
         TxD  <= line;
         busy <= state != IDLE;
         if (state == IDLE || tick) baud <= '0;
         else                       baud <= baud + BW'(1);
         if (tick) begin
            if ((state == DATA && !last_data) ||
                (state == STOP && !last_stop))
               bitn <= bitn + NW'(1);
            else
               bitn <= '0;
         end
         if (pop) begin
            shreg   <= mem[rd_ptr];
            par_bit <= (PARITY == 2) ? ~^mem[rd_ptr]
                                     : ^mem[rd_ptr];
         end else if (state == DATA && tick) begin
            shreg <= shreg >> 1;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parity/stop configurations,
// frames decoded from TxD and scored against queued characters.
module tb_uart_tx_fifo;
   localparam int CPB = 4;

   logic       clk, rst_n;
   logic       wr_en0, wr_en1, wr_en2;
   logic [7:0] wr_data0, wr_data1, wr_data2;
   logic       full0, full1, full2;
   logic       empty0, empty1, empty2;
   logic [4:0] count0, count1, count2;
   logic       ovf0, ovf1, ovf2;
   logic       busy0, busy1, busy2;
   logic       txd0, txd1, txd2;

   int checks = 0;
   int errors = 0;

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .DEPTH(16),
      .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .wr_data(wr_data0),
      .full(full0), .empty(empty0), .count(count0),
      .overflow(ovf0), .busy(busy0), .TxD(txd0));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .DEPTH(16),
      .PARITY(1), .STOP_BITS(2)) u1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_data(wr_data1),
      .full(full1), .empty(empty1), .count(count1),
      .overflow(ovf1), .busy(busy1), .TxD(txd1));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .DEPTH(16),
      .PARITY(2), .STOP_BITS(2)) u2 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_data(wr_data2),
      .full(full2), .empty(empty2), .count(count2),
      .overflow(ovf2), .busy(busy2), .TxD(txd2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected characters per instance, in send order
   logic [7:0] q0[$], q1[$], q2[$];

   bit          mon_act[3];
   bit          mon_skip[3];
   int          mon_cyc[3];
   int          mon_len[3];
   logic [7:0]  mon_dat[3];
   logic [63:0] mon_exp[3];
   logic [63:0] mon_got[3];

   function automatic int q_size(input int k);
      case (k)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic q_push(input int k, input logic [7:0] d);
      case (k)
         0: q0.push_back(d);
         1: q1.push_back(d);
         default: q2.push_back(d);
      endcase
   endtask

   task automatic q_pop(input int k, output logic [7:0] d);
      case (k)
         0: d = q0.pop_front();
         1: d = q1.pop_front();
         default: d = q2.pop_front();
      endcase
   endtask

   task automatic q_clear(input int k);
      case (k)
         0: q0.delete();
         1: q1.delete();
         default: q2.delete();
      endcase
   endtask

   function automatic logic busy_of(input int k);
      case (k)
         0: return busy0;
         1: return busy1;
         default: return busy2;
      endcase
   endfunction

   function automatic logic empty_of(input int k);
      case (k)
         0: return empty0;
         1: return empty1;
         default: return empty2;
      endcase
   endfunction

   function automatic int frame_len(input int par, input int stp);
      return CPB * (1 + 8 + ((par != 0) ? 1 : 0) + stp);
   endfunction

   // Expected line level for every clock of one frame
   function automatic logic [63:0] wave(input logic [7:0] d,
                                        input int par, input int stp);
      logic [15:0] b;
      logic [63:0] w;
      int n;
      b = '0;
      w = '0;
      n = 0;
      b[n] = 1'b0;
      n++;
      for (int i = 0; i < 8; i++) begin
         b[n] = d[i];
         n++;
      end
      if (par == 1) begin
         b[n] = ($countones(d) % 2) == 1;
         n++;
      end
      if (par == 2) begin
         b[n] = ($countones(d) % 2) == 0;
         n++;
      end
      for (int i = 0; i < stp; i++) begin
         b[n] = 1'b1;
         n++;
      end
      for (int c = 0; c < n * CPB; c++) w[c] = b[c / CPB];
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t",
                  name, got, exp, $time);
      end
   endtask

   task automatic mon_step(input int k, input logic line,
                           input int par, input int stp);
      logic [7:0] d;
      if (!rst_n) begin
         mon_act[k] = 1'b0;
         q_clear(k);
         return;
      end
      if (!mon_act[k]) begin
         if (line !== 1'b0) return;
         mon_act[k] = 1'b1;
         mon_cyc[k] = 0;
         mon_got[k] = '0;
         mon_len[k] = frame_len(par, stp);
         if (q_size(k) == 0) begin
            mon_skip[k] = 1'b1;
            checks++;
            errors++;
            $display("FAIL frame_u%0d: start bit at %0t, nothing queued",
                     k, $time);
         end else begin
            mon_skip[k] = 1'b0;
            q_pop(k, d);
            mon_dat[k] = d;
            mon_exp[k] = wave(d, par, stp);
         end
      end
      mon_got[k][mon_cyc[k]] = line;
      mon_cyc[k]++;
      if (mon_cyc[k] == mon_len[k]) begin
         mon_act[k] = 1'b0;
         if (!mon_skip[k]) begin
            checks++;
            if (mon_got[k] !== mon_exp[k]) begin
               errors++;
               $display("FAIL frame_u%0d data %02h: got %h want %h",
                        k, mon_dat[k], mon_got[k], mon_exp[k]);
            end
         end
      end
   endtask

   // Monitor samples just after each rising edge
   always @(posedge clk) begin
      #1;
      mon_step(0, txd0, 0, 1);
      mon_step(1, txd1, 1, 2);
      mon_step(2, txd2, 2, 2);
   end

   task automatic wr(input int k, input logic [7:0] d, input bit acc);
      case (k)
         0: begin wr_en0 = 1'b1; wr_data0 = d; end
         1: begin wr_en1 = 1'b1; wr_data1 = d; end
         default: begin wr_en2 = 1'b1; wr_data2 = d; end
      endcase
      if (acc) q_push(k, d);
      @(negedge clk);
      wr_en0 = 1'b0;
      wr_en1 = 1'b0;
      wr_en2 = 1'b0;
      wr_data0 = 8'($urandom);
      wr_data1 = 8'($urandom);
      wr_data2 = 8'($urandom);
   endtask

   task automatic wait_idle(input int k, input int limit);
      int t = 0;
      while (!(busy_of(k) === 1'b0 && empty_of(k) === 1'b1 &&
               !mon_act[k] && q_size(k) == 0) && t < limit) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= limit) begin
         errors++;
         $display("FAIL idle_u%0d: not idle after %0d cycles",
                  k, limit);
      end
   endtask

   task automatic span(input int k, output int n);
      int t = 0;
      n = 0;
      while (busy_of(k) !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      while (busy_of(k) === 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t, lows, bhi, nb;
      rst_n = 1'b0;
      wr_en0 = 1'b0;
      wr_en1 = 1'b0;
      wr_en2 = 1'b0;
      wr_data0 = '0;
      wr_data1 = '0;
      wr_data2 = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_txd", txd0, 1);
      check("rst_busy", busy0, 0);
      check("rst_full", full0, 0);
      check("rst_empty", empty0, 1);
      check("rst_count", count0, 0);
      check("rst_ovf", ovf0, 0);

      // Single 0xA5 frame: latency, length, idle afterwards
      wr(0, 8'hA5, 1);
      check("t1_txd_e0", txd0, 1);
      check("t1_empty_e0", empty0, 0);
      @(negedge clk);
      check("t1_txd_e1", txd0, 1);
      @(negedge clk);
      check("t1_txd_e2", txd0, 0);
      check("t1_busy_e2", busy0, 1);
      check("t1_count_e2", count0, 0);
      span(0, n);
      check("t1_busy_len", n, 40);
      check("t1_txd_end", txd0, 1);
      check("t1_empty_end", empty0, 1);
      wait_idle(0, 100);

      // Three back-to-back frames
      wr(0, 8'h41, 1);
      wr(0, 8'h42, 1);
      wr(0, 8'h43, 1);
      span(0, n);
      check("t2_busy_len", n, 120);
      wait_idle(0, 200);

      // Fill while busy, then overflow
      wr(0, 8'($urandom), 1);
      t = 0;
      while (busy0 !== 1'b1 && t < 10) begin
         @(negedge clk);
         t++;
      end
      check("t3_busy", busy0, 1);
      for (int i = 0; i < 16; i++) wr(0, 8'($urandom), 1);
      check("t3_count", count0, 16);
      check("t3_full", full0, 1);
      check("t3_ovf_pre", ovf0, 0);
      wr(0, 8'($urandom), 0);
      check("t3_ovf", ovf0, 1);
      check("t3_count_hold", count0, 16);
      @(negedge clk);
      check("t3_ovf_end", ovf0, 0);
      wait_idle(0, 17 * 40 + 200);

      // Parity and two stop bits
      wr(1, 8'h07, 1);
      span(1, n);
      check("t4_even_len", n, 48);
      wait_idle(1, 100);
      wr(2, 8'h07, 1);
      span(2, n);
      check("t4_odd_len", n, 48);
      wait_idle(2, 100);
      for (int i = 0; i < 4; i++) begin
         wr(1, 8'($urandom), 1);
         wr(2, 8'($urandom), 1);
      end
      wait_idle(1, 400);
      wait_idle(2, 400);

      // Reset during a data bit
      wr(0, 8'($urandom), 1);
      wr(0, 8'($urandom), 1);
      wr(0, 8'($urandom), 1);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("t5_txd", txd0, 1);
      check("t5_busy", busy0, 0);
      check("t5_count", count0, 0);
      check("t5_empty", empty0, 1);
      rst_n = 1'b1;
      lows = 0;
      bhi = 0;
      repeat (100) begin
         @(negedge clk);
         if (txd0 !== 1'b1) lows++;
         if (busy0 !== 1'b0) bhi++;
      end
      check("t5_quiet_txd", lows, 0);
      check("t5_quiet_busy", bhi, 0);
      wr(0, 8'($urandom), 1);
      wait_idle(0, 100);

      // Push and end-of-stop pop on the same edge at DEPTH-1
      for (int i = 0; i < 17; i++) wr(0, 8'($urandom), 1);
      check("t6_count_full", count0, 16);
      t = 0;
      while (count0 !== 5'd15 && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("t6_count_15", count0, 15);
      repeat (39) @(negedge clk);
      check("t6_count_pre", count0, 15);
      wr(0, 8'($urandom), 1);
      check("t6_count_post", count0, 15);
      check("t6_full_post", full0, 0);
      check("t6_ovf_post", ovf0, 0);
      wait_idle(0, 18 * 40 + 200);

      // Random bursts with random gaps
      for (int r = 0; r < 4; r++) begin
         nb = $urandom_range(2, 8);
         for (int i = 0; i < nb; i++) begin
            wr(0, 8'($urandom), 1);
            repeat ($urandom_range(0, 2)) begin
               wr_data0 = 8'($urandom);
               @(negedge clk);
            end
         end
         wait_idle(0, 8 * 40 + 200);
      end
      check("end_ovf", ovf0, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
